// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the DDR3 read/write line arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_UPDATE
  } arb_state_e;

  // Default-geometry burst lengths and frame size (960x540 quadrants in 1920x1080)
  localparam int unsigned WR_BEATS   = 960 / 8;
  localparam int unsigned RD_BEATS   = 1920 / 8;
  localparam int unsigned FRAME_SIZE = 1920 * 1080;

  // Start pixel of quadrant k: bit0 selects the right half, bit1 the lower half
  function automatic int unsigned quad_base(input logic [1:0] k,
                                            input int unsigned mem_h,
                                            input int unsigned mem_v,
                                            input int unsigned disp_h);
    int unsigned b;
    b = 0;
    if (k[0]) b = b + mem_h;
    if (k[1]) b = b + mem_v * disp_h;
    return b;
  endfunction

  localparam int unsigned QUAD_BASE0 = quad_base(2'd0, 960, 540, 1920);
  localparam int unsigned QUAD_BASE1 = quad_base(2'd1, 960, 540, 1920);
  localparam int unsigned QUAD_BASE2 = quad_base(2'd2, 960, 540, 1920);
  localparam int unsigned QUAD_BASE3 = quad_base(2'd3, 960, 540, 1920);

endpackage

// File: rtl/axi_arb_rr4.sv
// 4-way round-robin picker: first requester after last_i (wrapping) wins.
module axi_arb_rr4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_i + 2'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rw_arbiter.sv
// Line-burst scheduler for four video writers and one display reader on one DDR3 port.
// Define AXI_ARB_PINGPONG_EN for double-buffered frame banks.
module axi_rw_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 28,
  parameter int MEM_BURST_LEN = 8,
  parameter int MEM_H_PIXEL   = 960,
  parameter int MEM_V_PIXEL   = 540,
  parameter int DISP_H        = 1920,
  parameter int DISP_V        = 1080
) (
  input  logic                  ddrphy_clkin,
  input  logic                  rst_n,
  input  logic [3:0]            axi_wr_req,
  input  logic                  axi_rd_req,
  input  logic [3:0]            video_frame_rst,
  input  logic                  rd_frame_rst,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_wr,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  input  logic                  cmd_done,
  output logic [3:0]            wr_grant,
  output logic                  rd_grant,
  output logic                  busy
);

  localparam int unsigned WR_LEN = MEM_H_PIXEL / MEM_BURST_LEN;
  localparam int unsigned RD_LEN = DISP_H / MEM_BURST_LEN;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DISP_H);
  localparam logic [9:0]  WR_LAST = 10'(MEM_V_PIXEL - 1);
  localparam logic [10:0] RD_LAST = 11'(DISP_V - 1);
  localparam logic [ADDR_WIDTH-1:0] WR_BASE [4] = '{
    ADDR_WIDTH'(quad_base(2'd0, MEM_H_PIXEL, MEM_V_PIXEL, DISP_H)),
    ADDR_WIDTH'(quad_base(2'd1, MEM_H_PIXEL, MEM_V_PIXEL, DISP_H)),
    ADDR_WIDTH'(quad_base(2'd2, MEM_H_PIXEL, MEM_V_PIXEL, DISP_H)),
    ADDR_WIDTH'(quad_base(2'd3, MEM_H_PIXEL, MEM_V_PIXEL, DISP_H))
  };

  if (DISP_H / MEM_BURST_LEN > 255) begin : g_len_chk
    $error("read burst of %0d beats does not fit cmd_len", DISP_H / MEM_BURST_LEN);
  end

  arb_state_e            state_q;
  logic                  cmd_valid_q, cmd_wr_q, rd_grant_q, busy_q, sup_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, rd_addr_q;
  logic [7:0]            cmd_len_q;
  logic [3:0]            wr_grant_q;
  logic [1:0]            last_wr_q, own_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q [4];
  logic [9:0]            wr_line_q [4];
  logic [10:0]           rd_line_q;
  logic [3:0]            wr_gnt_d;
  logic [1:0]            wr_idx_d;
  logic                  own_rst;
  logic [ADDR_WIDTH-1:0] wr_ofs, rd_ofs;

`ifdef AXI_ARB_PINGPONG_EN
  localparam logic [ADDR_WIDTH-1:0] BANK_OFS = ADDR_WIDTH'(DISP_H * DISP_V);
  logic wr_bank_q, rd_bank_q;
  assign wr_ofs = wr_bank_q ? BANK_OFS : '0;
  assign rd_ofs = rd_bank_q ? BANK_OFS : '0;
`else
  assign wr_ofs = '0;
  assign rd_ofs = '0;
`endif

  axi_arb_rr4 u_rr4 (
    .req_i  (axi_wr_req),
    .last_i (last_wr_q),
    .gnt_o  (wr_gnt_d)
  );

  always_comb begin
    wr_idx_d = 2'd0;
    for (int i = 0; i < 4; i++) if (wr_gnt_d[i]) wr_idx_d = 2'(i);
  end

  // Frame restart of whoever currently owns the port
  assign own_rst = rd_grant_q ? rd_frame_rst : video_frame_rst[own_q];

  always_ff @(posedge ddrphy_clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      wr_grant_q  <= '0;
      rd_grant_q  <= 1'b0;
      busy_q      <= 1'b0;
      sup_q       <= 1'b0;
      last_wr_q   <= 2'd3;
      own_q       <= 2'd0;
      rd_addr_q   <= '0;
      rd_line_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        wr_addr_q[k] <= WR_BASE[k];
        wr_line_q[k] <= '0;
      end
`ifdef AXI_ARB_PINGPONG_EN
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|axi_wr_req) begin
            state_q     <= ST_CMD;
            busy_q      <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_wr_q    <= 1'b1;
            cmd_len_q   <= 8'(WR_LEN);
            cmd_addr_q  <= (video_frame_rst[wr_idx_d] ? WR_BASE[wr_idx_d]
                                                      : wr_addr_q[wr_idx_d]) + wr_ofs;
            wr_grant_q  <= wr_gnt_d;
            own_q       <= wr_idx_d;
            last_wr_q   <= wr_idx_d;
            sup_q       <= 1'b0;
          end else if (axi_rd_req) begin
            state_q     <= ST_CMD;
            busy_q      <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_wr_q    <= 1'b0;
            cmd_len_q   <= 8'(RD_LEN);
            cmd_addr_q  <= (rd_frame_rst ? '0 : rd_addr_q) + rd_ofs;
            rd_grant_q  <= 1'b1;
            sup_q       <= 1'b0;
          end
        end
        ST_CMD: begin
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_WAIT;
          end
          if (own_rst) sup_q <= 1'b1;
        end
        ST_WAIT: begin
          if (cmd_done) state_q <= ST_UPDATE;
          if (own_rst) sup_q <= 1'b1;
        end
        ST_UPDATE: begin
          // A restart during the burst already reloaded the counters
          if (!sup_q) begin
            if (rd_grant_q) begin
              if (rd_line_q == RD_LAST) begin
                rd_line_q <= '0;
                rd_addr_q <= '0;
`ifdef AXI_ARB_PINGPONG_EN
                rd_bank_q <= ~wr_bank_q;
`endif
              end else begin
                rd_line_q <= rd_line_q + 11'd1;
                rd_addr_q <= rd_addr_q + STRIDE;
              end
            end else if (wr_line_q[own_q] == WR_LAST) begin
              wr_line_q[own_q] <= '0;
              wr_addr_q[own_q] <= WR_BASE[own_q];
`ifdef AXI_ARB_PINGPONG_EN
              if (own_q == 2'd0) wr_bank_q <= ~wr_bank_q;
`endif
            end else begin
              wr_line_q[own_q] <= wr_line_q[own_q] + 10'd1;
              wr_addr_q[own_q] <= wr_addr_q[own_q] + STRIDE;
            end
          end
          wr_grant_q <= '0;
          rd_grant_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
      // Restarts come last so they override any same-cycle line advance
      for (int k = 0; k < 4; k++) begin
        if (video_frame_rst[k]) begin
          wr_addr_q[k] <= WR_BASE[k];
          wr_line_q[k] <= '0;
        end
      end
      if (rd_frame_rst) begin
        rd_addr_q <= '0;
        rd_line_q <= '0;
`ifdef AXI_ARB_PINGPONG_EN
        rd_bank_q <= ~wr_bank_q;
`endif
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign wr_grant  = wr_grant_q;
  assign rd_grant  = rd_grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed self-checking bench for axi_rw_arbiter (default geometry).
module tb_axi_rw_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  axi_wr_req;
  logic        axi_rd_req;
  logic [3:0]  video_frame_rst;
  logic        rd_frame_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [27:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_done;
  logic [3:0]  wr_grant;
  logic        rd_grant;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef AXI_ARB_PINGPONG_EN
  localparam int WRAP0 = 2073600;
`else
  localparam int WRAP0 = 0;
`endif

  axi_rw_arbiter dut (
    .ddrphy_clkin    (clk),
    .rst_n           (rst_n),
    .axi_wr_req      (axi_wr_req),
    .axi_rd_req      (axi_rd_req),
    .video_frame_rst (video_frame_rst),
    .rd_frame_rst    (rd_frame_rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_wr          (cmd_wr),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .cmd_done        (cmd_done),
    .wr_grant        (wr_grant),
    .rd_grant        (rd_grant),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (cmd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(cmd_valid), 1);
  endtask

  // Wait for a command, check it, accept in one cycle, optionally pulse
  // frame restarts during WAIT, then signal completion.
  task automatic serve(input string tag, input logic [3:0] eg, input logic erd,
                       input int ea, input logic [3:0] vfr);
    wait_valid(tag);
    chk({tag, "_gnt"},  32'(wr_grant), 32'(eg));
    chk({tag, "_rgnt"}, 32'(rd_grant), 32'(erd));
    chk({tag, "_wr"},   32'(cmd_wr),   erd ? 0 : 1);
    chk({tag, "_len"},  32'(cmd_len),  erd ? 240 : 120);
    chk({tag, "_addr"}, 32'(cmd_addr), ea);
    chk({tag, "_busy"}, 32'(busy),     1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk({tag, "_vdrop"}, 32'(cmd_valid), 0);
    video_frame_rst = vfr;
    @(negedge clk);
    video_frame_rst = 4'b0000;
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea;
    rst_n = 1'b0;
    axi_wr_req = 4'b0000;
    axi_rd_req = 1'b0;
    video_frame_rst = 4'b0000;
    rd_frame_rst = 1'b0;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_wr",    32'(cmd_wr),    0);
    chk("rst_addr",  32'(cmd_addr),  0);
    chk("rst_len",   32'(cmd_len),   0);
    chk("rst_gnt",   32'(wr_grant),  0);
    chk("rst_rgnt",  32'(rd_grant),  0);
    chk("rst_busy",  32'(busy),      0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // All writers requesting: round-robin order and quadrant bases
    axi_wr_req = 4'b1111;
    serve("rr0", 4'b0001, 1'b0, 0,       4'b0000);
    serve("rr1", 4'b0010, 1'b0, 960,     4'b0000);
    serve("rr2", 4'b0100, 1'b0, 1036800, 4'b0000);
    serve("rr3", 4'b1000, 1'b0, 1037760, 4'b0000);
    serve("rr4", 4'b0001, 1'b0, 1920,    4'b0000);

    // Write beats read, then reads advance and restart
    axi_wr_req = 4'b0100;
    axi_rd_req = 1'b1;
    serve("wr_first", 4'b0100, 1'b0, 1038720, 4'b0000);
    axi_wr_req = 4'b0000;
    serve("rd0", 4'b0000, 1'b1, 0,    4'b0000);
    serve("rd1", 4'b0000, 1'b1, 1920, 4'b0000);
    axi_rd_req = 1'b0;
    rd_frame_rst = 1'b1;
    @(negedge clk);
    rd_frame_rst = 1'b0;
    axi_rd_req = 1'b1;
    serve("rd_rst", 4'b0000, 1'b1, 0, 4'b0000);
    axi_rd_req = 1'b0;

    // Slow accept: command held stable, cmd_done ignored outside WAIT
    axi_wr_req = 4'b1000;
    wait_valid("stall");
    axi_wr_req = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      chk("stall_valid", 32'(cmd_valid), 1);
      chk("stall_addr",  32'(cmd_addr),  1039680);
      chk("stall_len",   32'(cmd_len),   120);
      chk("stall_wr",    32'(cmd_wr),    1);
      chk("stall_gnt",   32'(wr_grant),  32'(4'b1000));
      cmd_done = (c == 3);
      @(negedge clk);
    end
    cmd_done = 1'b0;
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("stall_acc_valid", 32'(cmd_valid), 0);
    chk("stall_acc_busy",  32'(busy),      1);
    @(negedge clk);
    chk("stall_wait_busy", 32'(busy), 1);
    chk("stall_wait_gnt",  32'(wr_grant), 32'(4'b1000));
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("stall_upd_busy", 32'(busy), 1);
    @(negedge clk);
    chk("stall_idle_busy", 32'(busy), 0);
    chk("stall_idle_gnt",  32'(wr_grant), 0);

    // Channel 1 restart during WAIT of line 5
    axi_wr_req = 4'b0010;
    serve("c1_l1", 4'b0010, 1'b0, 2880,  4'b0000);
    serve("c1_l2", 4'b0010, 1'b0, 4800,  4'b0000);
    serve("c1_l3", 4'b0010, 1'b0, 6720,  4'b0000);
    serve("c1_l4", 4'b0010, 1'b0, 8640,  4'b0000);
    serve("c1_l5", 4'b0010, 1'b0, 10560, 4'b0010);
    serve("c1_rs", 4'b0010, 1'b0, 960,   4'b0000);
    serve("c1_n1", 4'b0010, 1'b0, 2880,  4'b0000);
    axi_wr_req = 4'b0000;

    // Channel 0 through a whole frame and its wrap
    video_frame_rst = 4'b0001;
    @(negedge clk);
    video_frame_rst = 4'b0000;
    axi_wr_req = 4'b0001;
    for (int i = 0; i < 541; i++) begin
      ea = (i < 540) ? i * 1920 : WRAP0;
      serve($sformatf("c0_l%0d", i), 4'b0001, 1'b0, ea, 4'b0000);
    end
    axi_wr_req = 4'b0000;

    // Read after a read frame restart starts at address 0 (bank 0)
    rd_frame_rst = 1'b1;
    @(negedge clk);
    rd_frame_rst = 1'b0;
    axi_rd_req = 1'b1;
    serve("rd_final", 4'b0000, 1'b1, 0, 4'b0000);
    axi_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
